sequential_multiplier: RTL and testbench

SEQUENTIAL_MULTIPLIER -- requirements
Module: sequential_multiplier

---
 rtl/sequential_multiplier_pkg.sv | 27 ++
 rtl/sequential_multiplier_booth_step.sv | 32 +++
 rtl/sequential_multiplier.sv | 104 ++++++++++
 tb/tb_sequential_multiplier.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sequential_multiplier_pkg.sv
// Shared types and constants for the radix-2 Booth sequential multiplier.
package sequential_multiplier_pkg;

  localparam int SEQ_MULT_DEFAULT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_t;

  // Booth recoding of the (q0, q-1) pair.
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sequential_multiplier_booth_step.sv
// One combinational radix-2 Booth iteration: add/sub/none on the W+1 bit
// accumulator, then an arithmetic right shift of {acc, q, q-1}.
module booth_step
  import sequential_multiplier_pkg::*;
#(
  parameter int W = SEQ_MULT_DEFAULT_W
) (
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] q_i,
  input  logic         qm1_i,
  input  logic [W:0]   m_i,
  output logic [W:0]   acc_o,
  output logic [W-1:0] q_o,
  output logic         qm1_o
);

  logic [W:0] sum;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sum = acc_i;
    case (booth_decode(q_i[0], qm1_i))
      OP_ADD:  sum = acc_i + m_i;
      OP_SUB:  sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
    acc_o = {sum[W], sum[W:1]};
    q_o   = {sum[0], q_i[W-1:1]};
    qm1_o = q_i[0];
  end

endmodule

// File: rtl/sequential_multiplier.sv
// Signed W x W sequential multiplier, one Booth step per cycle, W-cycle latency.
// Optional `busy` output is enabled by defining SEQ_MULT_BUSY_EN.
module sequential_multiplier
  import sequential_multiplier_pkg::*;
#(
  parameter int W = SEQ_MULT_DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
`ifdef SEQ_MULT_BUSY_EN
  ,
  output logic           busy
`endif
);

  localparam int CW = $clog2(W);

  state_t         state_q;
  logic [W:0]     m_q;
  logic [W:0]     acc_q;
  logic [W-1:0]   q_q;
  logic           qm1_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] product_q;
  logic           done_q;
  logic           busy_q;

  logic [W:0]     acc_d;
  logic [W-1:0]   q_d;
  logic           qm1_d;

  booth_step #(.W(W)) u_booth_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .acc_o (acc_d),
    .q_o   (q_d),
    .qm1_o (qm1_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= BUSY;
            m_q     <= {a[W-1], a};
            acc_q   <= '0;
            q_q     <= b;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + 1'b1;
          // The exact product always fits the low 2W bits of {acc, q}.
          if (cnt_q == CW'(W - 1)) begin
            state_q   <= DONE;
            product_q <= {acc_d[W-1:0], q_d};
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_q;
  assign done    = done_q;

`ifdef SEQ_MULT_BUSY_EN
  assign busy = busy_q;
`else
  logic unused_busy;
  assign unused_busy = busy_q;
`endif

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench for sequential_multiplier (default W = 32): directed
// vectors, randomized operands against a plain-arithmetic model, reset/start corners.
module tb_sequential_multiplier;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           done;
`ifdef SEQ_MULT_BUSY_EN
  logic           busy;
`endif

  int checks = 0;
  int errors = 0;

  sequential_multiplier #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .done    (done)
`ifdef SEQ_MULT_BUSY_EN
    ,
    .busy    (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(actual), actual,
               $signed(expected), expected);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return sx * sy;
  endfunction

  // Launches one operation and checks done clear, latency, hidden intermediates and the result.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [63:0] exp, input bit disturb);
    logic [63:0] prev;
    int          cyc;
    bit          leak;
`ifdef SEQ_MULT_BUSY_EN
    bit          busy_bad;
`endif
    @(negedge clk);
    prev  = product;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    check({name, "_done_clr"}, 64'(done), 64'd0);
    cyc  = 0;
    leak = 1'b0;
`ifdef SEQ_MULT_BUSY_EN
    busy_bad = 1'b0;
`endif
    while (!done && cyc < 100) begin
`ifdef SEQ_MULT_BUSY_EN
      if (busy !== 1'b1) busy_bad = 1'b1;
`endif
      if (disturb && cyc < W - 4) begin
        start = 1'($urandom_range(0, 1));
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!done && product !== prev) leak = 1'b1;
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(cyc), 64'(W));
    check({name, "_product"}, product, exp);
    check({name, "_no_leak"}, 64'(leak), 64'd0);
`ifdef SEQ_MULT_BUSY_EN
    check({name, "_busy"}, 64'(busy_bad || busy !== 1'b0), 64'd0);
`endif
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [63:0]  held;
    bit           seen_done;

    vecs[0] = '{"m15x10",   32'd15,         32'd10,         64'd150};
    vecs[1] = '{"mn25x12",  -32'sd25,       32'd12,         -64'sd300};
    vecs[2] = '{"mn8xn8",   -32'sd8,        -32'sd8,        64'd64};
    vecs[3] = '{"m0x123",   32'd0,          32'd123,        64'd0};
    vecs[4] = '{"mmaxpos",  32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'd4611686014132420609};
    vecs[5] = '{"mmaxneg",  32'h8000_0000,  32'h8000_0000,  64'd4611686018427387904};
    vecs[6] = '{"mnegpos",  32'h8000_0000,  32'h7FFF_FFFF,  -64'sd4611686016279904256};
    vecs[7] = '{"m1xn1",    32'd1,          32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("rst_product", product, 64'd0);
    check("rst_done", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
    end

    // Result holds in DONE while start stays low.
    held = product;
    repeat (5) @(posedge clk);
    #1;
    check("hold_product", product, held);
    check("hold_done", 64'(done), 64'd1);

    // Back-to-back: done is high, next start must drop it on the accepting edge.
    check("b2b_done_before", 64'(done), 64'd1);
    run_op("b2b", -32'sd7, 32'd9, -64'sd63, 1'b0);

    // start toggling and operand changes while BUSY must not disturb the result.
    run_op("disturb", 32'd15, 32'd10, 64'd150, 1'b1);

    // Mid-operation reset aborts immediately and no done follows.
    @(negedge clk);
    a     = 32'd1234;
    b     = 32'd5678;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_product", product, 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", 64'(seen_done), 64'd0);
    run_op("after_rst", 32'd1234, 32'd5678, 64'd7006652, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'h8000_0000;
      run_op($sformatf("rand%0d", i), ra, rb, model(ra, rb), (i % 4) == 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
